// File: rtl/simcomp_pkg.sv
// rtl/simcomp_pkg.sv - opcodes, FSM states and decode helper for simcomp_core (SIMCOMP_BRANCH_EN aware)
package simcomp_pkg;

  localparam logic [3:0] OP_HALT  = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h3;
  localparam logic [3:0] OP_ADD   = 4'h7;
  localparam logic [3:0] OP_SUB   = 4'h8;
  localparam logic [3:0] OP_JMP   = 4'h9;
  localparam logic [3:0] OP_JZ    = 4'hA;
  localparam logic [3:0] OP_STORE = 4'hB;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GET_ADDR = 3'd1,
    FETCH    = 3'd2,
    DECODE   = 3'd3,
    OPERAND  = 3'd4,
    EXECUTE  = 3'd5,
    HALT     = 3'd6,
    FAULT    = 3'd7
  } state_t;

  // Opcodes whose OPERAND cycle reads data memory.
  function automatic logic reads_mem(input logic [3:0] op);
    return (op == OP_LOAD) || (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/simcomp_regfile.sv
// rtl/simcomp_regfile.sv - register file, one async read port, one write port, async clear
module simcomp_regfile #(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] regs [0:(1<<IDX_W)-1];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < (1 << IDX_W); i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata = regs[raddr];

endmodule

// File: rtl/simcomp_core.sv
// rtl/simcomp_core.sv - 5-cycle multicycle accumulator-style core; SIMCOMP_BRANCH_EN adds JMP/JZ
module simcomp_core
  import simcomp_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 8,
  parameter int REG_IDX_W = 4,
  parameter int RESET_PC  = 20
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] ir,
  output logic [DATA_W-1:0] mbr,
  output logic [ADDR_W-1:0] mar,
  output logic              zero,
  output logic              halted,
  output logic              fault
);

  if (DATA_W < 4 + REG_IDX_W + ADDR_W) begin : g_width_check
    $error("simcomp_core: DATA_W too small for opcode, register index and address fields");
  end

  state_t                 state;
  logic [DATA_W-1:0]      mem [0:(1<<ADDR_W)-1];
  logic [3:0]             opcode;
  logic [REG_IDX_W-1:0]   idx;
  logic [ADDR_W-1:0]      opnd_addr;
  logic [DATA_W-1:0]      rf_rdata;
  logic [DATA_W-1:0]      rf_wdata;
  logic                   rf_we;
  logic                   mem_we;

  assign opcode    = ir[DATA_W-1 -: 4];
  assign idx       = ir[DATA_W-5 -: REG_IDX_W];
  assign opnd_addr = ir[ADDR_W-1:0];

  always_comb begin
    rf_we    = 1'b0;
    rf_wdata = mbr;
    if (state == EXECUTE) begin
      case (opcode)
        OP_LOAD: begin rf_we = 1'b1; rf_wdata = mbr;            end
        OP_ADD:  begin rf_we = 1'b1; rf_wdata = rf_rdata + mbr; end
        OP_SUB:  begin rf_we = 1'b1; rf_wdata = rf_rdata - mbr; end
        default: ;
      endcase
    end
  end

  assign mem_we = (state == EXECUTE) && (opcode == OP_STORE);

  simcomp_regfile #(.DATA_W(DATA_W), .IDX_W(REG_IDX_W)) u_regfile (
    .clock (clock),
    .reset (reset),
    .we    (rf_we),
    .waddr (idx),
    .wdata (rf_wdata),
    .raddr (idx),
    .rdata (rf_rdata)
  );

  // Memory is not reset; a STORE caught by reset is dropped because reset gates the write.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (state == IDLE && prog_we) mem[prog_addr] <= prog_data;
      else if (mem_we)              mem[mar]       <= mbr;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      pc     <= ADDR_W'(RESET_PC);
      ir     <= '0;
      mbr    <= '0;
      mar    <= '0;
      zero   <= 1'b0;
      halted <= 1'b0;
      fault  <= 1'b0;
    end else begin
      case (state)
        IDLE:     if (run) state <= GET_ADDR;
        GET_ADDR: begin mar <= pc; state <= FETCH; end
        FETCH: begin
          ir    <= mem[mar];
          pc    <= pc + 1'b1;
          state <= DECODE;
        end
        DECODE:   begin mar <= opnd_addr; state <= OPERAND; end
        OPERAND: begin
          if (reads_mem(opcode))       mbr <= mem[mar];
          else if (opcode == OP_STORE) mbr <= rf_rdata;
          state <= EXECUTE;
        end
        EXECUTE: begin
          state <= GET_ADDR;
          case (opcode)
            OP_HALT: begin state <= HALT; halted <= 1'b1; end
            OP_LOAD, OP_ADD, OP_SUB: zero <= (rf_wdata == '0);
            OP_STORE: ;
`ifdef SIMCOMP_BRANCH_EN
            OP_JMP: pc <= opnd_addr;
            OP_JZ:  if (zero) pc <= opnd_addr;
`endif
            default: begin state <= FAULT; fault <= 1'b1; end
          endcase
        end
        HALT:     state <= HALT;
        FAULT:    state <= FAULT;
        default:  state <= FAULT;
      endcase
    end
  end

endmodule

// File: tb/tb_simcomp_core.sv
// tb/tb_simcomp_core.sv - scoreboard bench for simcomp_core; expectations follow SIMCOMP_BRANCH_EN
module tb_simcomp_core;
  import simcomp_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        run;
  logic        prog_we;
  logic [7:0]  prog_addr;
  logic [15:0] prog_data;
  logic [7:0]  pc;
  logic [15:0] ir;
  logic [15:0] mbr;
  logic [7:0]  mar;
  logic        zero;
  logic        halted;
  logic        fault;

  simcomp_core dut (
    .clock     (clock),
    .reset     (reset),
    .run       (run),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .pc        (pc),
    .ir        (ir),
    .mbr       (mbr),
    .mar       (mar),
    .zero      (zero),
    .halted    (halted),
    .fault     (fault)
  );

  always #5 clock = ~clock;

  localparam int T_PC = 0, T_IR = 1, T_MBR = 2, T_MAR = 3, T_ZERO = 4;
  localparam int T_HALTED = 5, T_FAULT = 6, T_MEM = 7, T_REG = 8, T_STATE = 9;

  typedef struct {
    int          tag;
    int          addr;
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t sb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic logic [31:0] sample(input int tag, input int addr);
    case (tag)
      T_PC:     return 32'(pc);
      T_IR:     return 32'(ir);
      T_MBR:    return 32'(mbr);
      T_MAR:    return 32'(mar);
      T_ZERO:   return 32'(zero);
      T_HALTED: return 32'(halted);
      T_FAULT:  return 32'(fault);
      T_MEM:    return 32'(dut.mem[addr]);
      T_REG:    return 32'(dut.u_regfile.regs[addr]);
      default:  return 32'(dut.state);
    endcase
  endfunction

  always @(negedge clock) begin
    while (sb.size() > 0) begin
      chk_t        c;
      logic [31:0] act;
      c   = sb.pop_front();
      act = sample(c.tag, c.addr);
      checks++;
      if (act !== c.exp) begin
        errors++;
        $display("FAIL %s: got %0h expected %0h", c.name, act, c.exp);
      end
    end
  end

  task automatic chk(input int tag, input int addr, input logic [31:0] exp, input string name);
    chk_t c;
    c.tag = tag; c.addr = addr; c.exp = exp; c.name = name;
    sb.push_back(c);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic flush();
    @(negedge clock);
    #1;
  endtask

  task automatic load(input int a, input logic [15:0] d);
    prog_we = 1'b1; prog_addr = 8'(a); prog_data = d;
    step(1);
    prog_we = 1'b0;
  endtask

  task automatic do_run();
    run = 1'b1;
    step(1);
    run = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; run = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    step(2);
    reset = 1'b0;
    checks++;
    if (pc !== 8'd20) begin
      errors++;
      $display("FAIL direct_reset_pc: got %0h expected %0h", pc, 8'd20);
    end
    chk(T_PC, 0, 32'd20, "reset_pc");
    chk(T_IR, 0, 32'h0, "reset_ir");
    chk(T_MBR, 0, 32'h0, "reset_mbr");
    chk(T_MAR, 0, 32'h0, "reset_mar");
    chk(T_ZERO, 0, 32'h0, "reset_zero");
    chk(T_HALTED, 0, 32'h0, "reset_halted");
    chk(T_FAULT, 0, 32'h0, "reset_fault");
    chk(T_STATE, 0, 32'(IDLE), "reset_state");
    flush();

    for (int i = 0; i < 256; i++) load(i, 16'h0000);

    // load/add/store/halt
    load(20, 16'h311E); load(21, 16'h711F); load(22, 16'hB120); load(23, 16'h0000);
    load(30, 16'h0005); load(31, 16'h0008);
    do_run();
    step(19);
    chk(T_HALTED, 0, 32'h0, "las_halted_early");
    flush();
    step(1);
    checks++;
    if (halted !== 1'b1) begin
      errors++;
      $display("FAIL direct_las_halted: got %0h expected %0h", halted, 1'b1);
    end
    chk(T_HALTED, 0, 32'h1, "las_halted");
    chk(T_PC, 0, 32'd24, "las_pc");
    chk(T_MEM, 32, 32'd13, "las_mem32");
    chk(T_REG, 1, 32'd13, "las_r1");
    chk(T_ZERO, 0, 32'h0, "las_zero");
    chk(T_MBR, 0, 32'd13, "las_mbr");
    flush();
    step(5);
    chk(T_HALTED, 0, 32'h1, "las_halt_held");
    chk(T_PC, 0, 32'd24, "las_pc_held");
    flush();

    // reset during EXECUTE of the STORE
    do_reset();
    chk(T_REG, 1, 32'h0, "rst_r1_clear");
    chk(T_MEM, 32, 32'd13, "rst_mem_kept");
    flush();
    load(32, 16'h0077);
    do_run();
    step(14);
    chk(T_STATE, 0, 32'(EXECUTE), "mid_state_exec");
    chk(T_MBR, 0, 32'd13, "mid_mbr");
    flush();
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk(T_MEM, 32, 32'h0077, "mid_mem32_kept");
    chk(T_PC, 0, 32'd20, "mid_pc");
    chk(T_STATE, 0, 32'(IDLE), "mid_state_idle");
    flush();
    step(1);
    do_run();
    step(20);
    chk(T_MEM, 32, 32'd13, "rerun_mem32");
    chk(T_REG, 1, 32'd13, "rerun_r1");
    chk(T_HALTED, 0, 32'h1, "rerun_halted");
    flush();

    // wraparound add plus ignored prog_we during execution
    do_reset();
    load(20, 16'h321E); load(21, 16'h721F); load(22, 16'h0000);
    load(30, 16'hFFFF); load(31, 16'h0001);
    do_run();
    step(3);
    prog_we = 1'b1; prog_addr = 8'd40; prog_data = 16'h1234;
    step(1);
    prog_we = 1'b0;
    step(1);
    chk(T_REG, 2, 32'hFFFF, "wrap_load_r2");
    chk(T_ZERO, 0, 32'h0, "wrap_load_zero");
    flush();
    step(5);
    chk(T_REG, 2, 32'h0000, "wrap_add_r2");
    chk(T_ZERO, 0, 32'h1, "wrap_add_zero");
    chk(T_MEM, 40, 32'h0000, "progwe_ignored");
    flush();

    // undefined opcode
    do_reset();
    load(20, 16'h5000);
    do_run();
    step(4);
    chk(T_FAULT, 0, 32'h0, "fault_early");
    flush();
    step(1);
    checks++;
    if (fault !== 1'b1) begin
      errors++;
      $display("FAIL direct_fault_set: got %0h expected %0h", fault, 1'b1);
    end
    chk(T_FAULT, 0, 32'h1, "fault_set");
    chk(T_PC, 0, 32'd21, "fault_pc");
    chk(T_REG, 0, 32'h0, "fault_r0");
    chk(T_HALTED, 0, 32'h0, "fault_not_halted");
    flush();
    step(100);
    chk(T_FAULT, 0, 32'h1, "fault_sticky");
    chk(T_PC, 0, 32'd21, "fault_pc_held");
    chk(T_STATE, 0, 32'(FAULT), "fault_state");
    flush();

    // SUB to zero then JZ 0x28
    do_reset();
    load(20, 16'h311E); load(21, 16'h811E); load(22, 16'hA028);
    load(30, 16'h0005); load(40, 16'h0000);
    do_run();
    step(10);
    chk(T_REG, 1, 32'h0, "br_sub_r1");
    chk(T_ZERO, 0, 32'h1, "br_sub_zero");
    flush();
    step(5);
`ifdef SIMCOMP_BRANCH_EN
    chk(T_PC, 0, 32'h28, "br_jz_pc");
    chk(T_FAULT, 0, 32'h0, "br_jz_nofault");
    flush();
    step(5);
    chk(T_HALTED, 0, 32'h1, "br_target_halt");
    chk(T_PC, 0, 32'h29, "br_target_pc");
`else
    chk(T_FAULT, 0, 32'h1, "br_undef_fault");
    chk(T_PC, 0, 32'd23, "br_undef_pc");
`endif
    flush();
    step(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/simcomp_core.md
SIMCOMP_CORE -- requirements
Module: simcomp_core

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- DATA_W, 16, word and instruction width.
- ADDR_W, 8, memory address width; memory depth is 2**ADDR_W words.
- REG_IDX_W, 4, register-index width; the register file holds 2**REG_IDX_W registers.
- RESET_PC, 20, PC value after reset.
REQ-002 Ports (name, direction, width, meaning) SHALL be:
- clock, in, 1, sole clock; all state updates on its rising edge.
- reset, in, 1, asynchronous, active-high.
- run, in, 1, leave IDLE and begin execution.
- prog_we, in, 1, program-load write enable.
- prog_addr, in, ADDR_W, program-load address.
- prog_data, in, DATA_W, program-load data.
- pc, out, ADDR_W, program counter.
- ir, out, DATA_W, instruction register.
- mbr, out, DATA_W, memory buffer register.
- mar, out, ADDR_W, memory address register.
- zero, out, 1, zero flag.
- halted, out, 1, core is in HALT.
- fault, out, 1, core is in FAULT.
REQ-003 Elaboration SHALL fail unless DATA_W >= 4 + REG_IDX_W + ADDR_W.

Function
REQ-004 Instruction fields SHALL be: opcode = ir[DATA_W-1 -: 4]; register index = the next REG_IDX_W bits below the opcode; operand address = ir[ADDR_W-1:0].
REQ-005 Opcodes SHALL be: 0x0 HALT, 0x3 LOAD, 0x7 ADD, 0x8 SUB, 0xB STORE; 0x9 JMP and 0xA JZ exist only under REQ-017.
REQ-006 States SHALL be IDLE, GET_ADDR, FETCH, DECODE, OPERAND, EXECUTE, HALT, FAULT.
REQ-007 IDLE SHALL go to GET_ADDR on the cycle run=1; IDLE is the only state in which prog_we writes memory, and prog_we in any other state SHALL be ignored.
REQ-008 Sequencing SHALL be one state per cycle, 5 cycles per instruction:
- GET_ADDR: mar<=pc.
- FETCH: ir<=mem[mar]; pc<=pc+1.
- DECODE: mar<=operand address.
- OPERAND: mbr<=mem[mar] for LOAD/ADD/SUB; mbr<=R[idx] for STORE.
- EXECUTE: performs the operation, then returns to GET_ADDR.
REQ-009 EXECUTE SHALL do: LOAD R[idx]<=mbr; ADD R[idx]<=R[idx]+mbr; SUB R[idx]<=R[idx]-mbr; STORE mem[mar]<=mbr.
REQ-010 ADD and SUB SHALL wrap modulo 2**DATA_W with no carry output; zero SHALL be updated by LOAD, ADD and SUB only, to (result==0).
REQ-011 HALT opcode SHALL enter HALT in EXECUTE; HALT is held, halted=1, until reset.
REQ-012 Any undefined opcode SHALL enter FAULT in EXECUTE with no register or memory write; FAULT is sticky, fault=1, until reset.
REQ-013 pc SHALL wrap from 2**ADDR_W-1 to 0 without fault.
REQ-014 The run level SHALL be ignored outside IDLE.

Reset
REQ-015 Reset SHALL set, immediately and in any state including mid-instruction: state=IDLE, pc=RESET_PC, ir=0, mbr=0, mar=0, zero=0, halted=0, fault=0, and all registers=0.
REQ-016 Memory contents SHALL be preserved across reset; an in-flight STORE interrupted by reset SHALL not write.

Configuration
REQ-017 With SIMCOMP_BRANCH_EN defined:
- JMP SHALL set pc<=operand address in EXECUTE.
- JZ SHALL set pc<=operand address when zero=1, otherwise leave pc unchanged.
- Both SHALL skip the OPERAND memory read.
REQ-018 Without SIMCOMP_BRANCH_EN, opcodes 0x9 and 0xA SHALL be undefined and handled per REQ-012.

Structure
REQ-019 Package simcomp_pkg SHALL hold the opcode constants and the state enum typedef.
REQ-020 The register file SHALL be the sub-module simcomp_regfile (one read port, one write port, asynchronous clear on reset).

Verification
REQ-021 Load/add/store: preload mem[20..23] = 311E, 711F, B120, 0000 and mem[30]=5, mem[31]=8; pulse run -> after 20 cycles mem[32]=13, R1=13, halted=1, pc=24.
REQ-022 Wrap: mem[30]=FFFF, mem[31]=0001, LOAD then ADD into R2 -> R2=0000, zero=1.
REQ-023 Fault: mem[20]=5000 -> fault=1 five cycles after run; pc=21; no register changes; stays in FAULT for 100 cycles.
REQ-024 Reset mid-instruction: assert reset during EXECUTE of STORE to mem[32] -> mem[32] unchanged, pc=20, state=IDLE; a fresh run re-executes correctly.
REQ-025 Branch (SIMCOMP_BRANCH_EN): SUB R1 from itself, then JZ 0x28 -> pc=0x28; without the macro the same program sets fault=1.
REQ-026 Program port: prog_we pulsed while executing -> the memory word is unchanged.
